key_press_tracker: RTL and testbench
====================================

// Module: key_press_tracker
// PURPOSE
//  Consumes per-frame centroids (x, y, valid pulse) from the centre-of-mass stage.
//  Smooths x with an EMA filter and maps it to a piano key index.
//  Classifies "pressed" from y, debounces over frames, emits note_on/note_off events
//  to the synth/MIDI stage over a valid/ready handshake.
// PARAMETERS
//  KEY_X0          64   x pixel of the left edge of key 0
//  KEY_WIDTH       40   key width in pixels (>=1)
//  NUM_KEYS        24   number of keys (<=128)
//  PRESS_Y         600  y_in >= PRESS_Y means finger is down
//  ALPHA_SHIFT     2    EMA: xf += (x - xf) >>> ALPHA_SHIFT
//  DEBOUNCE_FRAMES 3    equal consecutive candidates needed to commit
//  MISS_FRAMES     4    frames without a centroid before forced release
//  BASE_NOTE       60   MIDI note of key 0
// PORTS
//  clk_in          in   1   system clock
//  rst_in          in   1   reset, asynchronous, active-high
//  x_in            in   11  centroid x
//  y_in            in   10  centroid y
//  valid_in        in   1   1-cycle centroid strobe
//  frame_in        in   1   1-cycle end-of-frame strobe (tabulate)
//  event_ready_in  in   1   downstream accepts event
//  event_valid_out out  1   event pending
//  event_note_out  out  7   MIDI note of event
//  event_on_out    out  1   1 = note_on, 0 = note_off
//  pressed_out     out  1   committed pressed state
//  key_out         out  7   committed key index
//  busy_out        out  1   FSM not IDLE; valid_in dropped
// BEHAVIOUR
//  Reset (async): all outputs 0, FSM IDLE, filter unprimed, counters 0, committed = released.
//    event_valid_out drops in the same instant.
//  FSM states:
//  - IDLE: valid_in -> update filter (first sample after reset/release loads xf = x_in directly),
//    latch y_in, clear seen-flag-miss counter, go to MAP.
//    frame_in with no valid_in since last frame_in -> miss_cnt++ (saturating).
//    miss_cnt == MISS_FRAMES -> candidate = released, go to DEBOUNCE.
//    valid_in and frame_in in the same cycle: centroid counts for that frame.
//  - MAP: start x_to_key; wait for done (<= NUM_KEYS+2 cycles).
//    candidate = {key, y>=PRESS_Y}.
//    xf < KEY_X0 or key >= NUM_KEYS -> candidate released.
//  - DEBOUNCE:
//    - candidate == last candidate -> deb_cnt++ (sat), else deb_cnt = 1.
//    - deb_cnt reaches DEBOUNCE_FRAMES and candidate != committed:
//      - committed pressed -> EMIT_OFF (old key);
//      - else if candidate pressed -> EMIT_ON;
//      - commit candidate.
//    - otherwise -> IDLE.
//    A released candidate's key field is ignored in comparison.
//  - EMIT_OFF: event_valid_out = 1, note = BASE_NOTE + old key, on = 0.
//    Hold stable until event_ready_in; then go to EMIT_ON if new candidate pressed, else IDLE.
//  - EMIT_ON: same as EMIT_OFF with new key, on = 1; -> IDLE on ready.
//  - Key change while pressed always yields off(old) then on(new), never on-on.
//  Arithmetic:
//  - EMA uses a 12-bit signed difference; arithmetic shift; xf is 11 bits unsigned.
//  - x_to_key subtracts KEY_X0 then iteratively subtracts KEY_WIDTH, 1 per cycle.
//  - Forced release (miss) resets the filter to unprimed.
//  - Counters saturate, never wrap.
// STRUCTURE
//  Package key_tracker_pkg: state enum (IDLE, MAP, DEBOUNCE, EMIT_OFF, EMIT_ON),
//    candidate struct {key[6:0], pressed}.
//  Sub-module x_to_key: ports clk_in, rst_in, start_in, x_in[10:0], done_out, key_out[6:0], oor_out.
//    Implements an iterative subtractor.
// TESTING
//  1. 3 frames of x=284, y=650: event note_on 65 after 3rd centroid; key_out=5, pressed_out=1.
//  2. Continuation of 1; then 3 frames of x=284, y=300: note_off 65; pressed_out=0; no note_on.
//  3. Pressed on key 5, then x moves to 324 (key 6, y=650) for enough frames:
//     filter settles, then off 65 followed by on 66, in that order.
//  4. Pressed on key 5, then 4 frame_in with no valid_in: note_off 65 after 4th frame.
//     Next centroid loads filter directly.
//  5. event_ready_in held 0 for 20 cycles: event fields stable, busy_out=1, valid_in ignored.
//     Then ready=1 completes the transfer in 1 cycle.
//  6. x=40 (<KEY_X0) and x=1100 (key>=24): never pressed, no events.
//     Assert rst_in mid-EMIT_ON: outputs 0 asynchronously.

Source files
------------

// File: rtl/key_tracker_pkg.sv
// ============================================================================
// key_tracker_pkg : shared FSM encodings and candidate type for the key tracker
// Rev 1.0
// ============================================================================
`default_nettype none

package key_tracker_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MAP      = 3'd1;
    localparam logic [2:0] ST_DEBOUNCE = 3'd2;
    localparam logic [2:0] ST_EMIT_OFF = 3'd3;
    localparam logic [2:0] ST_EMIT_ON  = 3'd4;

    typedef logic [2:0] state_t;

    typedef struct packed {
        logic [6:0] key;
        logic       pressed;
    } cand_t;

    // Two released candidates are equal whatever their key field holds.
    function automatic logic cand_eq(input cand_t a, input cand_t b);
        return (a.pressed == b.pressed) && (!a.pressed || (a.key == b.key));
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_press_tracker_x_to_key.sv
// ============================================================================
// x_to_key : iterative x-to-key divider, one KEY_WIDTH subtraction per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module x_to_key #(
    parameter int KEY_X0    = 64,
    parameter int KEY_WIDTH = 40,
    parameter int NUM_KEYS  = 24
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [10:0] x_in,
    output logic        done_out,
    output logic [6:0]  key_out,
    output logic        oor_out
);

    localparam logic [10:0] c_X0 = 11'(KEY_X0);
    localparam logic [10:0] c_W  = 11'(KEY_WIDTH);
    localparam logic [7:0]  c_N  = 8'(NUM_KEYS);

    logic        r_busy;
    logic        r_done;
    logic        r_oor;
    logic [10:0] r_rem;
    logic [7:0]  r_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_oor  <= 1'b0;
            r_rem  <= '0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (start_in) begin
                r_cnt <= '0;
                if (x_in < c_X0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_oor  <= 1'b1;
                end else begin
                    r_rem  <= x_in - c_X0;
                    r_oor  <= 1'b0;
                    r_busy <= 1'b1;
                end
            end else if (r_busy) begin
                // Stop as soon as the count leaves the keyboard so runtime stays bounded.
                if (r_cnt >= c_N) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_oor  <= 1'b1;
                end else if (r_rem >= c_W) begin
                    r_rem <= r_rem - c_W;
                    r_cnt <= r_cnt + 8'd1;
                end else begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done_out = r_done;
    assign oor_out  = r_oor;
    assign key_out  = r_cnt[6:0];

endmodule

`default_nettype wire

// File: rtl/key_press_tracker.sv
// ============================================================================
// key_press_tracker : EMA-smoothed centroid to piano key, debounced press
//                     detection and note_on/note_off event generation
// Rev 1.0
// ============================================================================
`default_nettype none

module key_press_tracker
    import key_tracker_pkg::*;
#(
    parameter int KEY_X0          = 64,
    parameter int KEY_WIDTH       = 40,
    parameter int NUM_KEYS        = 24,
    parameter int PRESS_Y         = 600,
    parameter int ALPHA_SHIFT     = 2,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int MISS_FRAMES     = 4,
    parameter int BASE_NOTE       = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        frame_in,
    input  logic        event_ready_in,
    output logic        event_valid_out,
    output logic [6:0]  event_note_out,
    output logic        event_on_out,
    output logic        pressed_out,
    output logic [6:0]  key_out,
    output logic        busy_out
);

    localparam logic [9:0] c_PRESS_Y = 10'(PRESS_Y);
    localparam logic [7:0] c_DEB     = 8'(DEBOUNCE_FRAMES);
    localparam logic [7:0] c_MISS    = 8'(MISS_FRAMES);
    localparam logic [6:0] c_BASE    = 7'(BASE_NOTE);

    state_t      r_state;
    logic [10:0] r_xf;
    logic        r_primed;
    logic [9:0]  r_y;
    logic        r_seen;
    logic [7:0]  r_miss_cnt;
    logic [7:0]  r_deb_cnt;
    logic        r_force;
    logic        r_start;
    cand_t       r_cand;
    cand_t       r_last;
    cand_t       r_committed;
    logic [6:0]  r_note;
    logic [6:0]  r_pend_note;
    logic        r_pend_on;

    logic signed [11:0] w_diff;
    logic signed [11:0] w_step;
    logic [10:0]        w_xf_ema;
    logic               w_accept;
    logic [7:0]         w_deb_next;
    logic               w_map_done;
    logic [6:0]         w_map_key;
    logic               w_map_oor;

    assign w_diff   = $signed({1'b0, x_in}) - $signed({1'b0, r_xf});
    assign w_step   = w_diff >>> ALPHA_SHIFT;
    assign w_xf_ema = 11'(r_xf + w_step);
    assign w_accept = valid_in && (r_state == ST_IDLE);

    always_comb begin
        w_deb_next = 8'd1;
        if (r_force) begin
            w_deb_next = c_DEB;
        end else if (cand_eq(r_cand, r_last)) begin
            w_deb_next = (r_deb_cnt >= c_DEB) ? r_deb_cnt : r_deb_cnt + 8'd1;
        end
    end

    x_to_key #(
        .KEY_X0    (KEY_X0),
        .KEY_WIDTH (KEY_WIDTH),
        .NUM_KEYS  (NUM_KEYS)
    ) u_x_to_key (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start_in (r_start),
        .x_in     (r_xf),
        .done_out (w_map_done),
        .key_out  (w_map_key),
        .oor_out  (w_map_oor)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_xf        <= '0;
            r_primed    <= 1'b0;
            r_y         <= '0;
            r_seen      <= 1'b0;
            r_miss_cnt  <= '0;
            r_deb_cnt   <= '0;
            r_force     <= 1'b0;
            r_start     <= 1'b0;
            r_cand      <= '0;
            r_last      <= '0;
            r_committed <= '0;
            r_note      <= '0;
            r_pend_note <= '0;
            r_pend_on   <= 1'b0;
        end else begin
            r_start <= 1'b0;

            // A centroid arriving with the frame strobe belongs to that frame.
            if (frame_in) begin
                if (!r_seen && !w_accept && (r_miss_cnt < c_MISS))
                    r_miss_cnt <= r_miss_cnt + 8'd1;
                r_seen <= 1'b0;
            end else if (w_accept) begin
                r_seen <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        r_xf       <= r_primed ? w_xf_ema : x_in;
                        r_primed   <= 1'b1;
                        r_y        <= y_in;
                        r_miss_cnt <= '0;
                        r_start    <= 1'b1;
                        r_state    <= ST_MAP;
                    end else if (r_miss_cnt >= c_MISS) begin
                        r_cand     <= '{key: r_committed.key, pressed: 1'b0};
                        r_force    <= 1'b1;
                        r_primed   <= 1'b0;
                        r_miss_cnt <= '0;
                        r_state    <= ST_DEBOUNCE;
                    end
                end
                ST_MAP: begin
                    if (w_map_done) begin
                        r_cand  <= '{key: w_map_key,
                                     pressed: !w_map_oor && (r_y >= c_PRESS_Y)};
                        r_force <= 1'b0;
                        r_state <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    r_last    <= r_cand;
                    r_deb_cnt <= w_deb_next;
                    r_state   <= ST_IDLE;
                    if ((w_deb_next >= c_DEB) && !cand_eq(r_cand, r_committed)) begin
                        r_committed <= r_cand;
                        r_pend_on   <= r_cand.pressed;
                        r_pend_note <= c_BASE + r_cand.key;
                        // Releasing the old key always precedes pressing a new one.
                        if (r_committed.pressed) begin
                            r_note  <= c_BASE + r_committed.key;
                            r_state <= ST_EMIT_OFF;
                        end else if (r_cand.pressed) begin
                            r_note  <= c_BASE + r_cand.key;
                            r_state <= ST_EMIT_ON;
                        end
                    end
                end
                ST_EMIT_OFF: begin
                    if (event_ready_in) begin
                        if (r_pend_on) begin
                            r_note  <= r_pend_note;
                            r_state <= ST_EMIT_ON;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_EMIT_ON: begin
                    if (event_ready_in)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign event_valid_out = (r_state == ST_EMIT_OFF) || (r_state == ST_EMIT_ON);
    assign event_on_out    = (r_state == ST_EMIT_ON);
    assign event_note_out  = r_note;
    assign pressed_out     = r_committed.pressed;
    assign key_out         = r_committed.key;
    assign busy_out        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_key_press_tracker.sv
// ============================================================================
// tb_key_press_tracker : scoreboard bench for key_press_tracker
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_press_tracker;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        valid_in;
    logic        frame_in;
    logic        event_ready_in;
    logic        event_valid_out;
    logic [6:0]  event_note_out;
    logic        event_on_out;
    logic        pressed_out;
    logic [6:0]  key_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk_in = ~clk_in;

    key_press_tracker dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .x_in            (x_in),
        .y_in            (y_in),
        .valid_in        (valid_in),
        .frame_in        (frame_in),
        .event_ready_in  (event_ready_in),
        .event_valid_out (event_valid_out),
        .event_note_out  (event_note_out),
        .event_on_out    (event_on_out),
        .pressed_out     (pressed_out),
        .key_out         (key_out),
        .busy_out        (busy_out)
    );

    // Monitor: every completed handshake is matched against the expected-event queue.
    always @(negedge clk_in) begin
        if (!rst_in && event_valid_out && event_ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got on=%0d note=%0d expected none",
                         event_on_out, event_note_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({event_on_out, event_note_out} !== mon_exp) begin
                    errors++;
                    $display("FAIL event got on=%0d note=%0d expected on=%0d note=%0d",
                             event_on_out, event_note_out, mon_exp[7], mon_exp[6:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic centroid(input logic [10:0] x, input logic [9:0] y);
        @(posedge clk_in); #1;
        x_in = x; y_in = y; valid_in = 1'b1; frame_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0; frame_in = 1'b0;
        repeat (40) @(posedge clk_in);
        #1;
    endtask

    task automatic centroids(input int n, input logic [10:0] x, input logic [9:0] y);
        for (int i = 0; i < n; i++) centroid(x, y);
    endtask

    task automatic empty_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
            frame_in = 1'b1;
            @(posedge clk_in); #1;
            frame_in = 1'b0;
            repeat (8) @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {event_valid_out, event_note_out, event_on_out,
                   pressed_out, key_out, busy_out}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1;
        x_in = '0; y_in = '0; valid_in = 1'b0; frame_in = 1'b0;
        event_ready_in = 1'b1;
        @(posedge clk_in); #1;
        chk_all_zero("reset_outputs");
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;

        // Press key 5: (284-64)/40 = 5 -> note 65 after the third frame.
        exp_q.push_back({1'b1, 7'd65});
        centroids(2, 11'd284, 10'd650);
        chk("press_before_debounce", pressed_out, 0);
        centroid(11'd284, 10'd650);
        chk("press_pressed", pressed_out, 1);
        chk("press_key", key_out, 5);
        chk("press_busy", busy_out, 0);

        // Lift finger: y below threshold -> off 65 only.
        exp_q.push_back({1'b0, 7'd65});
        centroids(3, 11'd284, 10'd300);
        chk("release_pressed", pressed_out, 0);

        // Slide 5 -> 6: filter 294,301,306,310,313; key 6 from 306, commit on 313.
        exp_q.push_back({1'b1, 7'd65});
        centroids(3, 11'd284, 10'd650);
        exp_q.push_back({1'b0, 7'd65});
        exp_q.push_back({1'b1, 7'd66});
        centroids(5, 11'd324, 10'd650);
        chk("slide_key", key_out, 6);
        chk("slide_pressed", pressed_out, 1);

        // Missing centroids: release after the fourth empty frame.
        exp_q.push_back({1'b0, 7'd66});
        empty_frames(3);
        chk("miss3_still_pressed", pressed_out, 1);
        empty_frames(1);
        chk("miss4_released", pressed_out, 0);

        // Unprimed filter loads 524 directly -> key 11, note 71; downstream stalls.
        event_ready_in = 1'b0;
        exp_q.push_back({1'b1, 7'd71});
        centroids(3, 11'd524, 10'd650);
        for (int i = 0; i < 20; i++) begin
            valid_in = (i == 5);
            x_in = 11'd1000;
            y_in = 10'd0;
            @(posedge clk_in); #1;
            chk("stall_hold", {event_valid_out, event_on_out, event_note_out, busy_out},
                {1'b1, 1'b1, 7'd71, 1'b1});
        end
        valid_in = 1'b0;
        event_ready_in = 1'b1;
        @(posedge clk_in); #1;
        chk("stall_done_valid", event_valid_out, 0);
        chk("stall_done_busy", busy_out, 0);
        chk("stall_key", key_out, 11);
        repeat (30) @(posedge clk_in);
        #1;
        chk("ignored_centroid_idle", busy_out, 0);

        // Out-of-range centroids never press.
        exp_q.push_back({1'b0, 7'd71});
        empty_frames(4);
        chk("oor_start_released", pressed_out, 0);
        centroids(3, 11'd40, 10'd650);
        chk("left_of_keys", pressed_out, 0);
        empty_frames(4);
        centroids(3, 11'd1100, 10'd650);
        chk("right_of_keys", pressed_out, 0);
        chk("right_of_keys_busy", busy_out, 0);

        // Reset asserted while a note_on is stalled.
        empty_frames(4);
        event_ready_in = 1'b0;
        centroids(3, 11'd284, 10'd650);
        chk("pre_reset_event", {event_valid_out, event_on_out, event_note_out},
            {1'b1, 1'b1, 7'd65});
        @(negedge clk_in); #1;
        rst_in = 1'b1;
        #1;
        chk_all_zero("async_reset");
        event_ready_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        chk_all_zero("after_reset");

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
